// File: rtl/blk_match_sad_pkg.sv
// Shared constants, FSM encoding and pixel helper for the block-matching SAD stage.
// Geometry is fixed: 4x4 reference block inside a 7x7 search window.
package blk_match_pkg;

    localparam int PIX_W  = 8;
    localparam int REF_N  = 4;
    localparam int SRCH_N = 7;
    localparam int NCAND  = (SRCH_N - REF_N + 1) * (SRCH_N - REF_N + 1);
    localparam int SAD_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } match_st_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] d_s;
        if (a >= b) begin
            d_s = a - b;
        end else begin
            d_s = b - a;
        end
        return d_s;
    endfunction

endpackage

// File: rtl/blk_match_sad_if.sv
// Column-beat input bus and match-result bus of the block-matching stage.
interface blk_match_sad_if;
    import blk_match_pkg::*;

    logic             blk_ext_vsync;
    logic             ref_vld;
    logic [PIX_W-1:0] ref0, ref1, ref2, ref3;
    logic             srch_vld;
    logic [PIX_W-1:0] srch0, srch1, srch2, srch3, srch4, srch5, srch6;
    logic             busy;
    logic             drop_err;
    logic             match_vld;
    logic [SAD_W-1:0] min_sad;
    logic [1:0]       best_dx;
    logic [1:0]       best_dy;

    modport master (
        output blk_ext_vsync, ref_vld, ref0, ref1, ref2, ref3,
               srch_vld, srch0, srch1, srch2, srch3, srch4, srch5, srch6,
        input  busy, drop_err, match_vld, min_sad, best_dx, best_dy
    );

    modport slave (
        input  blk_ext_vsync, ref_vld, ref0, ref1, ref2, ref3,
               srch_vld, srch0, srch1, srch2, srch3, srch4, srch5, srch6,
        output busy, drop_err, match_vld, min_sad, best_dx, best_dy
    );

endinterface

// File: rtl/blk_match_sad_sad16.sv
// Combinational SAD of sixteen 8-bit pixel pairs: absolute differences
// feeding a four-level widening adder tree, so the 12-bit sum cannot overflow.
module sad16
    import blk_match_pkg::*;
(
    input  logic [15:0][PIX_W-1:0] pix_a,
    input  logic [15:0][PIX_W-1:0] pix_b,
    output logic [SAD_W-1:0]       sad
);

    logic [15:0][PIX_W-1:0] ad_s;
    logic [7:0][PIX_W:0]    l1_s;
    logic [3:0][PIX_W+1:0]  l2_s;
    logic [1:0][PIX_W+2:0]  l3_s;

    // Absolute differences, then pairwise sums growing one bit per level.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ad_s[i] = abs_diff(pix_a[i], pix_b[i]);
        end
        for (int i = 0; i < 8; i++) begin
            l1_s[i] = {1'b0, ad_s[2*i]} + {1'b0, ad_s[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            l2_s[i] = {1'b0, l1_s[2*i]} + {1'b0, l1_s[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            l3_s[i] = {1'b0, l2_s[2*i]} + {1'b0, l2_s[2*i+1]};
        end
        sad = {1'b0, l3_s[0]} + {1'b0, l3_s[1]};
    end

endmodule

// File: rtl/blk_match_sad.sv
// Collects a 4x4 reference block and 7x7 search window, scans the 16 candidate
// positions one per cycle and reports the lowest SAD (earliest candidate on ties).
module blk_match_sad
    import blk_match_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    blk_match_sad_if.slave bus
);

    match_st_t              state_r, state_nxt_s;
    logic [2:0]             ref_cnt_r, srch_cnt_r, ref_cnt_nxt_s, srch_cnt_nxt_s;
    logic [3:0]             cand_r;
    logic [PIX_W-1:0]       ref_r [REF_N][REF_N];
    logic [PIX_W-1:0]       win_r [SRCH_N][SRCH_N];
    logic [PIX_W-1:0]       ref_col_s [REF_N];
    logic [PIX_W-1:0]       srch_col_s [SRCH_N];
    logic                   loading_s, ref_ok_s, srch_ok_s, full_s, take_s;
    logic [15:0][PIX_W-1:0] cand_a_s, cand_b_s;
    logic [SAD_W-1:0]       sad_s, min_r, best_sad_s, min_sad_r;
    logic [3:0]             arg_r, best_k_s;
    logic                   busy_r, match_vld_r;
    logic [1:0]             best_dx_r, best_dy_r;

    assign ref_col_s  = '{bus.ref0, bus.ref1, bus.ref2, bus.ref3};
    assign srch_col_s = '{bus.srch0, bus.srch1, bus.srch2, bus.srch3,
                          bus.srch4, bus.srch5, bus.srch6};

    // Beat acceptance; a frame sync silently discards anything in its cycle.
    always_comb begin
        loading_s      = (state_r == IDLE) || (state_r == LOAD);
        ref_ok_s       = bus.ref_vld && loading_s && (ref_cnt_r < 3'(REF_N)) && !bus.blk_ext_vsync;
        srch_ok_s      = bus.srch_vld && loading_s && (srch_cnt_r < 3'(SRCH_N)) && !bus.blk_ext_vsync;
        ref_cnt_nxt_s  = ref_cnt_r + {2'b00, ref_ok_s};
        srch_cnt_nxt_s = srch_cnt_r + {2'b00, srch_ok_s};
        full_s         = (ref_cnt_nxt_s == 3'(REF_N)) && (srch_cnt_nxt_s == 3'(SRCH_N));
    end

    assign bus.drop_err = !bus.blk_ext_vsync &&
                          ((bus.ref_vld && !ref_ok_s) || (bus.srch_vld && !srch_ok_s));

    // Next-state logic; the last beat moves straight into the candidate scan.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.blk_ext_vsync) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (full_s)                      state_nxt_s = CALC;
                    else if (ref_ok_s || srch_ok_s)  state_nxt_s = LOAD;
                    else                             state_nxt_s = IDLE;
                end
                LOAD: begin
                    if (full_s) state_nxt_s = CALC;
                    else        state_nxt_s = LOAD;
                end
                CALC: begin
                    if (cand_r == 4'(NCAND - 1)) state_nxt_s = DONE;
                    else                         state_nxt_s = CALC;
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Candidate k = dy*4 + dx selects the 4x4 window at row dy, column dx.
    always_comb begin
        for (int r = 0; r < REF_N; r++) begin
            for (int c = 0; c < REF_N; c++) begin
                cand_a_s[r*REF_N + c] = ref_r[r][c];
                cand_b_s[r*REF_N + c] = win_r[3'(cand_r[3:2]) + 3'(r)][3'(cand_r[1:0]) + 3'(c)];
            end
        end
    end

    sad16 u_sad16 (
        .pix_a (cand_a_s),
        .pix_b (cand_b_s),
        .sad   (sad_s)
    );

    // Running minimum: first candidate always loads, later ones only if strictly smaller.
    always_comb begin
        take_s = (cand_r == 4'd0) || (sad_s < min_r);
        if (take_s) begin
            best_sad_s = sad_s;
            best_k_s   = cand_r;
        end else begin
            best_sad_s = min_r;
            best_k_s   = arg_r;
        end
    end

    // FSM state, beat counters and candidate index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ref_cnt_r  <= 3'd0;
            srch_cnt_r <= 3'd0;
            cand_r     <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (bus.blk_ext_vsync || (state_r == DONE)) begin
                ref_cnt_r  <= 3'd0;
                srch_cnt_r <= 3'd0;
            end else begin
                ref_cnt_r  <= ref_cnt_nxt_s;
                srch_cnt_r <= srch_cnt_nxt_s;
            end
            if ((state_r == CALC) && !bus.blk_ext_vsync) begin
                cand_r <= cand_r + 4'd1;
            end else begin
                cand_r <= 4'd0;
            end
        end
    end

    // Pixel storage: column j of each block lands at its beat count.
    always_ff @(posedge clk) begin
        if (ref_ok_s) begin
            for (int r = 0; r < REF_N; r++) begin
                ref_r[r][ref_cnt_r[1:0]] <= ref_col_s[r];
            end
        end
        if (srch_ok_s) begin
            for (int r = 0; r < SRCH_N; r++) begin
                win_r[r][srch_cnt_r] <= srch_col_s[r];
            end
        end
    end

    // Min/argmin tracking and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r       <= 12'd0;
            arg_r       <= 4'd0;
            busy_r      <= 1'b0;
            match_vld_r <= 1'b0;
            min_sad_r   <= 12'd0;
            best_dx_r   <= 2'd0;
            best_dy_r   <= 2'd0;
        end else begin
            busy_r      <= (state_nxt_s == CALC) || (state_nxt_s == DONE);
            match_vld_r <= 1'b0;
            if ((state_r == CALC) && !bus.blk_ext_vsync) begin
                min_r <= best_sad_s;
                arg_r <= best_k_s;
                if (cand_r == 4'(NCAND - 1)) begin
                    match_vld_r <= 1'b1;
                    min_sad_r   <= best_sad_s;
                    best_dx_r   <= best_k_s[1:0];
                    best_dy_r   <= best_k_s[3:2];
                end
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.match_vld = match_vld_r;
    assign bus.min_sad   = min_sad_r;
    assign bus.best_dx   = best_dx_r;
    assign bus.best_dy   = best_dy_r;

endmodule
